// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word requests and
// buffers {pc, instr} pairs for decode; redirects flush the buffer and drop stale responses.

module ifetch_queue_chk (
  input logic i_clk,
  input logic i_rst_n,
  input logic i_iq_push,
  input logic i_iq_full,
  input logic i_oq_push,
  input logic i_oq_full
);
  a_iq_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_iq_push && i_iq_full));
  a_oq_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_oq_push && i_oq_full));
endmodule

module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req_valid,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_req_ready,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_id_valid,
  output logic [31:0] o_id_instr,
  output logic [31:0] o_id_pc,
  input  logic        i_id_ready
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   CREDIT_MAX = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_oq [DEPTH];
  logic [AW-1:0] r_oq_rd, r_oq_wr;
  logic [31:0]   r_iq_pc [DEPTH];
  logic [31:0]   r_iq_instr [DEPTH];
  logic [AW-1:0] r_iq_rd, r_iq_wr;
  logic [CW-1:0] r_oc, r_ic, r_dc;
  logic          r_id_valid;
  logic [31:0]   r_id_pc, r_id_instr;

  logic          w_credit, w_req_valid, w_req_fire, w_rsp, w_drop, w_iq_push, w_iq_pop;
  logic [31:0]   w_oq_head, w_redirect_pc;
  logic [CW-1:0] w_ic_after_pop, w_oc_nxt, w_ic_nxt, w_dc_nxt;
  logic [AW-1:0] w_iq_rd_nxt, w_iq_wr_nxt;
  logic [31:0]   w_fetch_pc_nxt, w_head_pc_nxt, w_head_instr_nxt;

  // Credits count both in-flight requests and buffered instructions, so the buffer cannot overflow
  assign w_credit      = ({1'b0, r_oc} + {1'b0, r_ic}) < CREDIT_MAX;
  assign w_req_valid   = i_rst_n & ~i_redirect_valid & w_credit;
  assign w_req_fire    = w_req_valid & i_imem_req_ready;
  assign w_rsp         = i_imem_rsp_valid;
  assign w_drop        = (r_dc != {CW{1'b0}});
  assign w_iq_push     = w_rsp & ~w_drop & ~i_redirect_valid;
  assign w_iq_pop      = r_id_valid & i_id_ready & ~i_redirect_valid;
  assign w_oq_head     = r_oq[r_oq_rd];
  assign w_redirect_pc = i_redirect_pc & 32'hFFFF_FFFC;

  // Next-state of counters, pointers, fetch PC and the registered decode head
  always_comb begin
    w_oc_nxt       = r_oc + CW'(w_req_fire) - CW'(w_rsp);
    w_ic_after_pop = r_ic - CW'(w_iq_pop);
    if (i_redirect_valid) begin
      w_fetch_pc_nxt = w_redirect_pc;
      w_dc_nxt       = r_oc - CW'(w_rsp);
      w_ic_nxt       = {CW{1'b0}};
      w_iq_rd_nxt    = r_iq_rd;
      w_iq_wr_nxt    = r_iq_rd;
    end else begin
      w_fetch_pc_nxt = w_req_fire ? (r_fetch_pc + 32'd4) : r_fetch_pc;
      w_dc_nxt       = (w_rsp & w_drop) ? (r_dc - CW'(1'b1)) : r_dc;
      w_ic_nxt       = w_ic_after_pop + CW'(w_iq_push);
      w_iq_rd_nxt    = r_iq_rd + AW'(w_iq_pop);
      w_iq_wr_nxt    = r_iq_wr + AW'(w_iq_push);
    end
    // A push into a queue that is empty after the pop becomes the new head directly
    if (w_ic_nxt == {CW{1'b0}}) begin
      w_head_pc_nxt    = 32'h0000_0000;
      w_head_instr_nxt = 32'h0000_0000;
    end else if (w_ic_after_pop == {CW{1'b0}}) begin
      w_head_pc_nxt    = w_oq_head;
      w_head_instr_nxt = i_imem_rsp_data;
    end else begin
      w_head_pc_nxt    = r_iq_pc[w_iq_rd_nxt];
      w_head_instr_nxt = r_iq_instr[w_iq_rd_nxt];
    end
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_oq_rd    <= {AW{1'b0}};
      r_oq_wr    <= {AW{1'b0}};
      r_iq_rd    <= {AW{1'b0}};
      r_iq_wr    <= {AW{1'b0}};
      r_oc       <= {CW{1'b0}};
      r_ic       <= {CW{1'b0}};
      r_dc       <= {CW{1'b0}};
      r_id_valid <= 1'b0;
      r_id_pc    <= 32'h0000_0000;
      r_id_instr <= 32'h0000_0000;
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
      r_oq_rd    <= r_oq_rd + AW'(w_rsp);
      r_oq_wr    <= r_oq_wr + AW'(w_req_fire);
      r_iq_rd    <= w_iq_rd_nxt;
      r_iq_wr    <= w_iq_wr_nxt;
      r_oc       <= w_oc_nxt;
      r_ic       <= w_ic_nxt;
      r_dc       <= w_dc_nxt;
      r_id_valid <= (w_ic_nxt != {CW{1'b0}});
      r_id_pc    <= w_head_pc_nxt;
      r_id_instr <= w_head_instr_nxt;
    end
  end

  // Queue storage; validity is tracked by the counters, so entries need no reset
  always_ff @(posedge i_clk) begin
    if (w_req_fire) begin
      r_oq[r_oq_wr] <= r_fetch_pc;
    end
    if (w_iq_push) begin
      r_iq_pc[r_iq_wr]    <= w_oq_head;
      r_iq_instr[r_iq_wr] <= i_imem_rsp_data;
    end
  end

  assign o_imem_req_valid = w_req_valid;
  assign o_imem_req_addr  = r_fetch_pc;
  assign o_id_valid       = r_id_valid;
  assign o_id_pc          = r_id_pc;
  assign o_id_instr       = r_id_instr;

  ifetch_queue_chk u_chk (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_iq_push (w_iq_push),
    .i_iq_full (r_ic == CNT_FULL),
    .i_oq_push (w_req_fire),
    .i_oq_full (r_oc == CNT_FULL)
  );
endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: in-order memory model with programmable latency,
// expected decode PCs queued by the stimulus thread and checked by an independent monitor.

module tb_ifetch_queue;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, rsp_valid, redirect_valid, id_valid, id_ready;
  logic [31:0] req_addr, rsp_data, redirect_pc, id_instr, id_pc;

  typedef struct packed {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] exp_q[$];
  int n_cmp = 0, n_bad = 0, n_consumed = 0, cyc = 0, mem_k = 1;

  always #5 clk = ~clk;

  ifetch_queue #(.RESET_PC(RST_PC), .DEPTH(2)) u_dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .o_imem_req_valid (req_valid),
    .o_imem_req_addr  (req_addr),
    .i_imem_req_ready (req_ready),
    .i_imem_rsp_valid (rsp_valid),
    .i_imem_rsp_data  (rsp_data),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_id_valid       (id_valid),
    .o_id_instr       (id_instr),
    .o_id_pc          (id_pc),
    .i_id_ready       (id_ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // In-order memory: response for a request accepted in cycle N appears in cycle N+mem_k
  initial begin
    logic        s_fire, s_rst, s_rsp;
    logic [31:0] s_addr;
    req_ready = 1'b1;
    rsp_valid = 1'b0;
    rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      s_fire = req_valid & req_ready;
      s_addr = req_addr;
      s_rst  = rst_n;
      s_rsp  = rsp_valid;
      @(posedge clk);
      #1;
      cyc++;
      if (!s_rst) begin
        pend.delete();
      end else begin
        if (s_rsp && pend.size() > 0) void'(pend.pop_front());
        if (s_fire) pend.push_back('{addr: s_addr, due: cyc - 1 + mem_k});
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        rsp_valid = 1'b1;
        rsp_data  = mem_word(pend[0].addr);
      end else begin
        rsp_valid = 1'b0;
        rsp_data  = 32'h0;
      end
    end
  end

  // Monitor: every accepted decode handshake is compared against the scoreboard
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && !redirect_valid && id_valid && id_ready) begin
        n_consumed++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_instr: got pc %08h expected no instruction", id_pc);
        end else begin
          e = exp_q.pop_front();
          check("id_pc", id_pc, e);
          check("id_instr", id_instr, mem_word(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int          b;
    rst_n = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (3) step();
    check("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_id_instr", id_instr, 32'h0);
    check("rst_req_valid", {31'd0, req_valid}, 32'd0);

    // Free run from RESET_PC, wrapping through zero
    push_exp(RST_PC, 40);
    rst_n = 1'b1; id_ready = 1'b1;
    #1;
    check("first_req_valid", {31'd0, req_valid}, 32'd1);
    check("first_req_addr", req_addr, RST_PC);
    step();
    check("no_bypass_id_valid", {31'd0, id_valid}, 32'd0);
    step();
    check("latency_id_valid", {31'd0, id_valid}, 32'd1);
    check("latency_id_pc", id_pc, RST_PC);
    b = 0;
    while (n_consumed < 6 && b < 100) begin step(); b++; end
    check("free_run_budget", 32'(n_consumed >= 6), 32'd1);

    // Decode stall: head holds, requests stop when credits are exhausted
    id_ready = 1'b0;
    step(); step();
    held = id_pc;
    check("stall_id_valid", {31'd0, id_valid}, 32'd1);
    check("stall_head_pc", id_pc, exp_q[0]);
    repeat (3) step();
    check("stall_hold_pc", id_pc, held);
    check("stall_hold_instr", id_instr, mem_word(held));
    check("stall_credit", {31'd0, req_valid}, 32'd0);
    id_ready = 1'b1;
    b = 0;
    while (n_consumed < 14 && b < 100) begin step(); b++; end
    check("resume_budget", 32'(n_consumed >= 14), 32'd1);

    // Redirect with two requests outstanding
    mem_k = 3;
    b = 0;
    while (pend.size() != 2 && b < 30) begin step(); b++; end
    check("two_outstanding", pend.size(), 32'd2);
    exp_q.delete();
    push_exp(32'h0000_0100, 20);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    step();
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    check("redir_id_valid", {31'd0, id_valid}, 32'd0);
    check("redir_req_addr", req_addr, 32'h0000_0100);
    b = 0;
    while (exp_q.size() > 16 && b < 80) begin step(); b++; end
    check("redir_budget", 32'(exp_q.size() <= 16), 32'd1);
    mem_k = 1;

    // Redirect coinciding with a response and a decode pop
    b = 0;
    while (!(rsp_valid && id_valid) && b < 40) begin step(); b++; end
    check("coincide_found", {31'd0, rsp_valid & id_valid}, 32'd1);
    exp_q.delete();
    push_exp(32'h0000_0200, 20);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    check("coincide_id_valid", {31'd0, id_valid}, 32'd0);
    b = 0;
    while (exp_q.size() > 16 && b < 80) begin step(); b++; end
    check("coincide_budget", 32'(exp_q.size() <= 16), 32'd1);

    // Mid-stream reset with a non-empty queue
    id_ready = 1'b0;
    step(); step();
    check("pre_reset_id_valid", {31'd0, id_valid}, 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    step();
    check("mid_rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("mid_rst_id_pc", id_pc, 32'h0);
    check("mid_rst_req_valid", {31'd0, req_valid}, 32'd0);
    push_exp(RST_PC, 6);
    rst_n = 1'b1;
    #1;
    check("post_rst_req_valid", {31'd0, req_valid}, 32'd1);
    check("post_rst_req_addr", req_addr, RST_PC);
    id_ready = 1'b1;
    b = 0;
    while (exp_q.size() != 0 && b < 60) begin step(); b++; end
    id_ready = 1'b0;
    check("drain_budget", exp_q.size(), 32'd0);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
